// File: rtl/irq_ctrl.sv
// Six-source level/edge interrupt controller on the bridge bus; optional fixed-priority vectoring under IRQC_PRIO_EN.
// HWInt is registered state through combinational mask/priority (one edge from irq_in); reads are combinational; no backpressure.
module irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20,
  parameter int          NSRC      = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic            we,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  input  logic [NSRC-1:0] irq_in,
  output logic [5:0]      HWInt
);

  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] prev;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] mode_chg;
  logic [NSRC-1:0] pm;
  logic [NSRC-1:0] hw_sel;
  logic [31:0]     vec_word;
  logic            hit;
  logic [1:0]      off;
  logic            wr_pend;
  logic            wr_mask;
  logic            wr_mode;

  // Byte lanes and upper data bits carry no information for full-word registers.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wd};

  assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign off     = addr[3:2];
  assign wr_pend = we && hit && (off == 2'd0);
  assign wr_mask = we && hit && (off == 2'd1);
  assign wr_mode = we && hit && (off == 2'd2);

  assign rise     = irq_in & ~prev;
  assign w1c      = wr_pend ? wd[NSRC-1:0] : '0;
  assign mode_chg = wr_mode ? (wd[NSRC-1:0] ^ mode) : '0;

  // A mode flip discards whatever was latched under the old interpretation.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < NSRC; i++) begin
      if (mode_chg[i]) begin
        pend_nxt[i] = 1'b0;
      end else if (mode[i]) begin
        if (rise[i]) begin
          pend_nxt[i] = 1'b1;
        end else if (w1c[i]) begin
          pend_nxt[i] = 1'b0;
        end
      end else begin
        pend_nxt[i] = irq_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      mask <= '0;
      mode <= '0;
      prev <= '0;
    end else begin
      prev <= irq_in;
      pend <= pend_nxt;
      if (wr_mask) begin
        mask <= wd[NSRC-1:0];
      end
      if (wr_mode) begin
        mode <= wd[NSRC-1:0];
      end
    end
  end

  assign pm = pend & mask;

`ifdef IRQC_PRIO_EN
  logic [4:0] idx;

  // Scan from the top so the lowest-numbered active source is the last to win.
  always_comb begin
    idx    = '0;
    hw_sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pm[i]) begin
        idx       = 5'(i);
        hw_sel    = '0;
        hw_sel[i] = 1'b1;
      end
    end
  end

  assign vec_word = {|pm, 26'b0, idx};
`else
  assign hw_sel   = pm;
  assign vec_word = 32'b0;
`endif

  assign HWInt = 6'(hw_sel);

  always_comb begin
    rd = 32'b0;
    if (hit) begin
      case (off)
        2'd0:    rd = 32'(pend);
        2'd1:    rd = 32'(mask);
        2'd2:    rd = 32'(mode);
        default: rd = vec_word;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed vector bench for irq_ctrl: one table row per clock, plus hand-written same-cycle read/write checks.
module tb_irq_ctrl;

  localparam logic [31:0] B  = 32'h0000_7F20;
  localparam logic [31:0] AP = B + 32'h0;
  localparam logic [31:0] AM = B + 32'h4;
  localparam logic [31:0] AD = B + 32'h8;
  localparam logic [31:0] AV = B + 32'hC;

`ifdef IRQC_PRIO_EN
  localparam logic [5:0]  HW3  = 6'h01;
  localparam logic [31:0] VEC3 = 32'h8000_0000;
`else
  localparam logic [5:0]  HW3  = 6'h03;
  localparam logic [31:0] VEC3 = 32'h0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [5:0]  irq_in;
  logic [5:0]  HWInt;

  int checks;
  int errors;

  irq_ctrl #(.BASE_ADDR(B), .NSRC(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .wd     (wd),
    .rd     (rd),
    .irq_in (irq_in),
    .HWInt  (HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [5:0]  irq;
    logic [5:0]  hw;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [5:0] irq, input logic [5:0] hw, input logic [31:0] exp_rd);
    vec_t v;
    v.rst = r; v.we = w; v.addr = a; v.wd = d; v.irq = irq; v.hw = hw; v.rd = exp_rd;
    tbl.push_back(v);
  endtask

  task automatic chk_hw(input string name, input logic [5:0] exp);
    checks++;
    if (HWInt !== exp) begin
      errors++;
      $display("FAIL %s HWInt got %h expected %h", name, HWInt, exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic [31:0] exp);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL %s rd got %h expected %h", name, rd, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    addr   = AP;
    we     = 1'b0;
    wd     = 32'b0;
    irq_in = 6'b0;

    // Each row: inputs held across one rising edge; expectations sampled just after it.
    add(1, 0, AP, 0, 0, 0, 0);                     // reset state
    add(1, 0, AM, 0, 0, 0, 0);
    add(0, 1, AM, 1, 0, 0, 1);                     // level: MASK=1
    add(0, 0, AP, 0, 1, 6'h01, 1);                 // rise -> pending after one edge
    add(0, 1, AP, 1, 1, 6'h01, 1);                 // W1C ignored on level source
    add(0, 0, AP, 0, 1, 6'h01, 1);
    add(0, 0, AP, 0, 0, 0, 0);                     // drop clears after one edge
    add(0, 1, AD, 2, 0, 0, 2);                     // edge: MODE=2
    add(0, 1, AM, 2, 0, 0, 2);
    add(0, 0, AP, 0, 2, 6'h02, 2);                 // pulse latches
    add(0, 0, AP, 0, 0, 6'h02, 2);                 // held after pulse
    add(0, 0, AP, 0, 0, 6'h02, 2);
    add(0, 1, AP, 2, 0, 0, 0);                     // W1C clears
    add(0, 1, AP, 2, 2, 6'h02, 2);                 // rise and W1C together: set wins
    add(0, 0, AP, 0, 2, 6'h02, 2);                 // no new edge while high
    add(0, 1, AP, 2, 2, 0, 0);                     // W1C clears while line still high
    add(0, 0, AP, 0, 0, 0, 0);
    add(0, 1, AD, 3, 0, 0, 3);                     // masking: MODE=3
    add(0, 1, AM, 0, 0, 0, 0);
    add(0, 0, AP, 0, 3, 0, 3);                     // both pend, masked
    add(0, 0, AP, 0, 0, 0, 3);
    add(0, 1, AM, 2, 0, 6'h02, 2);
    add(0, 1, AM, 3, 0, HW3, 3);
    add(0, 0, AV, 0, 0, HW3, VEC3);
    add(0, 1, B + 32'h14, 0, 0, HW3, 0);           // miss: ignored, rd=0
    add(0, 0, AM, 0, 0, HW3, 3);
    add(0, 1, AM, 32'hFFFF_FFFF, 0, HW3, 32'h3F);  // upper bits dropped
    add(1, 1, AP, 0, 3, 0, 0);                     // reset overrides write and events
    add(0, 0, AM, 0, 0, 0, 0);
    add(0, 1, AM, 1, 1, 6'h01, 1);                 // mode switch: level pend
    add(0, 1, AD, 1, 1, 0, 1);                     // 0->1 clears, no rise since prev=1
    add(0, 0, AP, 0, 1, 0, 0);
    add(0, 0, AP, 0, 0, 0, 0);
    add(0, 0, AP, 0, 1, 6'h01, 1);                 // edge latch
    add(0, 1, AD, 0, 1, 0, 0);                     // 1->0 clears
    add(0, 0, AP, 0, 1, 6'h01, 1);                 // now tracks level
    add(0, 0, AP, 0, 0, 0, 0);
    add(0, 0, AP, 0, 1, 6'h01, 1);
    add(0, 1, AD, 0, 1, 6'h01, 0);                 // unchanged MODE write keeps PEND

    foreach (tbl[k]) begin
      @(negedge clk);
      reset  = tbl[k].rst;
      we     = tbl[k].we;
      addr   = tbl[k].addr;
      wd     = tbl[k].wd;
      irq_in = tbl[k].irq;
      @(posedge clk);
      #1;
      chk_hw($sformatf("vec%0d", k), tbl[k].hw);
      chk_rd($sformatf("vec%0d", k), tbl[k].rd);
    end

    // Same-cycle read and write of MASK: old value before the edge, new after.
    @(negedge clk);
    reset = 1'b0; we = 1'b1; addr = AM; wd = 32'h0; irq_in = 6'h01;
    #1;
    chk_rd("rw_same_old", 32'h1);
    @(posedge clk);
    #1;
    chk_rd("rw_same_new", 32'h0);
    chk_hw("rw_same_hw", 6'h00);

    // Pending survives while masked, reappears on unmask.
    @(negedge clk);
    we = 1'b1; addr = AM; wd = 32'h21; irq_in = 6'h21;
    @(posedge clk);
    #1;
    chk_hw("unmask_hw", 6'h21 & (HW3 == 6'h01 ? 6'h01 : 6'h21));
    @(negedge clk);
    we = 1'b0; addr = AV;
    #1;
    chk_rd("vec_read", (HW3 == 6'h01) ? 32'h8000_0000 : 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
